// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the branch resolve unit and the predictor that consumes PB_BUS.
// Holds the update-bus width and field offsets, the FSM state type and the mispredict rule.
package branch_resolve_pkg;

  localparam int PB_BUS_Wid      = 99;
  localparam int PB_INST_LSB     = 67;
  localparam int PB_DIRECT_BIT   = 66;
  localparam int PB_INDIRECT_BIT = 65;
  localparam int PB_TAKEN_BIT    = 64;
  localparam int PB_TARGET_LSB   = 32;
  localparam int PB_PC_LSB       = 0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } bru_state_e;

  // Direction differs, or both say taken but the targets differ.
  function automatic logic bru_mispredict(input logic pt, input logic tk,
                                          input logic [31:0] ptgt, input logic [31:0] tgt);
    return (pt != tk) || (pt && tk && (ptgt != tgt));
  endfunction

endpackage

// File: rtl/bru_update_fifo.sv
// Predictor-update FIFO: W-bit entries, DEPTH entries (power of two), synchronous reset.
// Enqueue into a full FIFO is allowed when a dequeue happens in the same cycle.
module bru_update_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         enq_i,
  input  logic [W-1:0] data_i,
  input  logic         deq_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          do_enq, do_deq;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[head_q];
  assign do_deq  = deq_i && !empty_o;
  assign do_enq  = enq_i && (!full_o || do_deq);

  // Pointer and occupancy next state; pointers wrap naturally at DEPTH.
  always_comb begin
    head_d  = do_deq ? head_q + AW'(1) : head_q;
    tail_d  = do_enq ? tail_q + AW'(1) : tail_q;
    count_d = count_q + (AW+1)'(do_enq) - (AW+1)'(do_deq);
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_enq) mem_q[tail_q] <= data_i;
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolve unit: checks execute-stage branches against their prediction, pulses
// predict_error with the correct-path PC, squashes wrong-path offers until that PC shows up,
// and queues every resolved branch for the predictor on PB_BUS.
// Optional macro BRU_PERF_CNT_EN adds saturating resolved-branch / mispredict counters.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int UQ_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  E_valid,
  input  logic [31:0]           E_pc,
  input  logic [31:0]           E_inst,
  input  logic                  E_direct,
  input  logic                  E_cond,
  input  logic                  E_pred_taken,
  input  logic [31:0]           E_pred_target,
  input  logic                  E_taken,
  input  logic [31:0]           E_target,
  output logic                  bru_allowin,
  input  logic                  ex_en,
  input  logic                  ertn_flush,
  output logic                  predict_error,
  output logic [31:0]           redirect_pc,
  output logic [PB_BUS_Wid-1:0] PB_BUS
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]           perf_br_cnt,
  output logic [31:0]           perf_mis_cnt
`endif
);

  bru_state_e            state_q, state_d;
  logic                  pe_q, pe_d;
  logic [31:0]           redirect_q, redirect_d;
  logic                  is_br, flush, accept, pc_match, live, mis;
  logic                  uq_enq, uq_deq, uq_full, uq_empty;
  logic [PB_BUS_Wid-1:0] uq_wdata, uq_head;

  assign is_br       = E_direct | E_cond;
  assign flush       = ex_en | ertn_flush;
  assign uq_deq      = !uq_empty;
  assign bru_allowin = !is_br || !uq_full || uq_deq;
  assign accept      = E_valid && bru_allowin;
  // redirect_q doubles as the saved correct-path PC while squashing.
  assign pc_match    = (E_pc == redirect_q);
  assign live        = accept && !flush && ((state_q == ST_RUN) || pc_match);
  assign mis         = live && is_br && bru_mispredict(E_pred_taken, E_taken, E_pred_target, E_target);
  assign uq_enq      = live && is_br;

  // Pack the update record at the predictor's field offsets.
  always_comb begin
    uq_wdata                                = '0;
    uq_wdata[PB_INST_LSB +: 32]             = E_inst;
    uq_wdata[PB_DIRECT_BIT]                 = E_direct;
    uq_wdata[PB_INDIRECT_BIT]               = E_cond;
    uq_wdata[PB_TAKEN_BIT]                  = E_taken;
    uq_wdata[PB_TARGET_LSB +: 32]           = E_target;
    uq_wdata[PB_PC_LSB +: 32]               = E_pc;
  end

  // RUN/SQUASH next state plus the registered mispredict pulse and redirect PC.
  always_comb begin
    state_d    = state_q;
    pe_d       = mis;
    redirect_d = mis ? (E_taken ? E_target : E_pc + 32'd4) : redirect_q;
    case (state_q)
      ST_RUN:    if (mis) state_d = ST_SQUASH;
      ST_SQUASH: begin
        if (flush)                    state_d = ST_RUN;
        else if (accept && pc_match)  state_d = mis ? ST_SQUASH : ST_RUN;
      end
      default:   state_d = ST_RUN;
    endcase
  end

  // State, pulse and redirect registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_RUN;
      pe_q       <= 1'b0;
      redirect_q <= '0;
    end else begin
      state_q    <= state_d;
      pe_q       <= pe_d;
      redirect_q <= redirect_d;
    end
  end

  assign predict_error = pe_q;
  assign redirect_pc   = redirect_q;
  assign PB_BUS        = uq_empty ? '0 : uq_head;

  bru_update_fifo #(
    .W     (PB_BUS_Wid),
    .DEPTH (UQ_DEPTH)
  ) u_uq (
    .clk     (clk),
    .rstn    (rstn),
    .enq_i   (uq_enq),
    .data_i  (uq_wdata),
    .deq_i   (uq_deq),
    .full_o  (uq_full),
    .empty_o (uq_empty),
    .head_o  (uq_head)
  );

`ifdef BRU_PERF_CNT_EN
  logic [31:0] br_cnt_q, mis_cnt_q;

  // Saturating counters of resolved branches and mispredicts.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (uq_enq && (br_cnt_q  != 32'hFFFF_FFFF)) br_cnt_q  <= br_cnt_q + 32'd1;
      if (mis    && (mis_cnt_q != 32'hFFFF_FFFF)) mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign perf_br_cnt  = br_cnt_q;
  assign perf_mis_cnt = mis_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed vector table, randomized traffic against a reference
// model, a standalone update-FIFO fill/full check and, with BRU_PERF_CNT_EN, counter checks.
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  localparam int UQD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, E_valid, E_direct, E_cond, E_pred_taken, E_taken, ex_en, ertn_flush;
  logic [31:0] E_pc, E_inst, E_pred_target, E_target;
  logic        bru_allowin, predict_error;
  logic [31:0] redirect_pc;
  logic [98:0] PB_BUS;
`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_br_cnt, perf_mis_cnt;
`endif

  branch_resolve #(.UQ_DEPTH(UQD)) dut (
    .clk(clk), .rstn(rstn), .E_valid(E_valid), .E_pc(E_pc), .E_inst(E_inst),
    .E_direct(E_direct), .E_cond(E_cond), .E_pred_taken(E_pred_taken),
    .E_pred_target(E_pred_target), .E_taken(E_taken), .E_target(E_target),
    .bru_allowin(bru_allowin), .ex_en(ex_en), .ertn_flush(ertn_flush),
    .predict_error(predict_error), .redirect_pc(redirect_pc), .PB_BUS(PB_BUS)
`ifdef BRU_PERF_CNT_EN
    , .perf_br_cnt(perf_br_cnt), .perf_mis_cnt(perf_mis_cnt)
`endif
  );

  // Standalone FIFO instance so the full / enqueue-while-full cases can be forced.
  logic       f_rstn, f_enq, f_deq, f_full, f_empty;
  logic [7:0] f_d, f_head;
  bru_update_fifo #(.W(8), .DEPTH(4)) u_f (
    .clk(clk), .rstn(f_rstn), .enq_i(f_enq), .data_i(f_d), .deq_i(f_deq),
    .full_o(f_full), .empty_o(f_empty), .head_o(f_head)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [98:0] act, input logic [98:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rstn, valid, direct, cond, pt, tk, ex, ertn;
    logic [31:0] pc, ptgt, tgt;
    bit          chk;   // apply the table expectations below
    logic        e_pe;
    logic [31:0] e_rd;
    bit          ci;    // also check the PB_BUS direct/indirect bits
    logic        e_ind;
  } rec_t;

  function automatic rec_t mk(input logic rs, input logic v, input logic d, input logic c,
                              input logic pt, input logic tk, input logic ex, input logic er,
                              input logic [31:0] pc, input logic [31:0] ptgt, input logic [31:0] tgt,
                              input bit ck, input logic epe, input logic [31:0] erd,
                              input bit ci, input logic eind);
    rec_t r;
    r.rstn = rs; r.valid = v; r.direct = d; r.cond = c; r.pt = pt; r.tk = tk;
    r.ex = ex; r.ertn = er; r.pc = pc; r.ptgt = ptgt; r.tgt = tgt;
    r.chk = ck; r.e_pe = epe; r.e_rd = erd; r.ci = ci; r.e_ind = eind;
    return r;
  endfunction

  // Reference model state: squash flag/target, queue of expected bus words, counters.
  bit          m_sq;
  logic [31:0] m_sqpc, m_rd;
  logic        m_pe;
  logic [98:0] m_q[$];
  int unsigned m_br, m_mis;

  task automatic step(input rec_t r);
    logic        isbr, exp_allow, acc;
    logic [98:0] e, exp_pb;
    @(negedge clk);
    rstn = r.rstn; E_valid = r.valid; E_direct = r.direct; E_cond = r.cond;
    E_pred_taken = r.pt; E_taken = r.tk; ex_en = r.ex; ertn_flush = r.ertn;
    E_pc = r.pc; E_pred_target = r.ptgt; E_target = r.tgt; E_inst = {16'h5800, r.pc[15:0]};
    #1;
    isbr      = r.direct | r.cond;
    exp_allow = !isbr || (m_q.size() < UQD) || (m_q.size() > 0);
    chk("allowin", 99'(bru_allowin), 99'(exp_allow));
    @(posedge clk);
    if (!r.rstn) begin
      m_q.delete(); m_sq = 0; m_rd = '0; m_pe = 0; m_br = 0; m_mis = 0;
    end else begin
      acc = r.valid && exp_allow;
      if (m_q.size() > 0) void'(m_q.pop_front());
      m_pe = 0;
      if (r.ex || r.ertn) m_sq = 0;
      else if (acc && (!m_sq || r.pc == m_sqpc)) begin
        m_sq = 0;
        if (isbr) begin
          e = {E_inst, r.direct, r.cond, r.tk, r.tgt, r.pc};
          m_q.push_back(e);
          m_br++;
          if (r.pt != r.tk || (r.pt && r.tk && r.ptgt != r.tgt)) begin
            m_pe = 1; m_rd = r.tk ? r.tgt : r.pc + 32'd4;
            m_sq = 1; m_sqpc = m_rd; m_mis++;
          end
        end
      end
    end
    #1;
    exp_pb = (m_q.size() > 0) ? m_q[0] : '0;
    chk("predict_error", 99'(predict_error), 99'(m_pe));
    chk("redirect_pc", 99'(redirect_pc), 99'(m_rd));
    chk("PB_BUS", PB_BUS, exp_pb);
`ifdef BRU_PERF_CNT_EN
    chk("perf_br_cnt", 99'(perf_br_cnt), 99'(m_br));
    chk("perf_mis_cnt", 99'(perf_mis_cnt), 99'(m_mis));
`endif
    if (r.chk) begin
      chk("tbl_pe", 99'(predict_error), 99'(r.e_pe));
      chk("tbl_rd", 99'(redirect_pc), 99'(r.e_rd));
    end
    if (r.ci) begin
      chk("tbl_pb_indirect", 99'(PB_BUS[PB_INDIRECT_BIT]), 99'(r.e_ind));
      chk("tbl_pb_direct", 99'(PB_BUS[PB_DIRECT_BIT]), 99'(!r.e_ind));
    end
  endtask

  // Standalone FIFO step against a queue model.
  logic [7:0] f_q[$];
  task automatic fstep(input logic enq, input logic deq, input logic [7:0] d);
    @(negedge clk);
    f_enq = enq; f_deq = deq; f_d = d;
    @(posedge clk);
    if (deq && f_q.size() > 0) void'(f_q.pop_front());
    if (enq && f_q.size() < 4) f_q.push_back(d);
    #1;
    chk("fifo_full", 99'(f_full), 99'(f_q.size() == 4));
    chk("fifo_empty", 99'(f_empty), 99'(f_q.size() == 0));
    if (f_q.size() > 0) chk("fifo_head", 99'(f_head), 99'(f_q[0]));
  endtask

  rec_t tbl[$];

  initial begin
    rec_t r;
    logic [31:0] pc;
    bit mis;
    rstn = 0; E_valid = 0; E_direct = 0; E_cond = 0; E_pred_taken = 0; E_taken = 0;
    ex_en = 0; ertn_flush = 0; E_pc = '0; E_inst = '0; E_pred_target = '0; E_target = '0;
    f_rstn = 0; f_enq = 0; f_deq = 0; f_d = '0;
    m_sq = 0; m_sqpc = '0; m_rd = '0; m_pe = 0; m_br = 0; m_mis = 0;

    //          rs v  d  c  pt tk ex er  pc            ptgt          tgt           ck pe rd            ci ind
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 32'h0,        32'h0,        32'h0,        1, 0, 32'h0,        0, 0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 32'h0,        32'h0,        32'h0,        1, 0, 32'h0,        0, 0));
    // beq mispredicted not-taken
    tbl.push_back(mk(1,1,0,1,0,1,0,0, 32'h1C000010, 32'h0,        32'h1C000040, 1, 1, 32'h1C000040, 1, 1));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 32'h1C000040, 32'h0,        32'h0,        1, 0, 32'h1C000040, 0, 0));
    // b with wrong target, two wrong-path offers squashed, then the redirect PC arrives
    tbl.push_back(mk(1,1,1,0,1,1,0,0, 32'h50,       32'h100,      32'h104,      1, 1, 32'h104,      1, 0));
    tbl.push_back(mk(1,1,1,0,0,1,0,0, 32'h200,      32'h0,        32'h300,      1, 0, 32'h104,      0, 0));
    tbl.push_back(mk(1,1,0,1,0,1,0,0, 32'h204,      32'h0,        32'h300,      1, 0, 32'h104,      0, 0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 32'h104,      32'h0,        32'h0,        1, 0, 32'h104,      0, 0));
    tbl.push_back(mk(1,1,0,1,1,0,0,0, 32'h108,      32'h200,      32'h200,      1, 1, 32'h10C,      1, 1));
    // mispredict together with ex_en: no pulse, back in RUN
    tbl.push_back(mk(1,1,0,1,0,1,1,0, 32'h10C,      32'h0,        32'h500,      1, 0, 32'h10C,      0, 0));
    tbl.push_back(mk(1,1,1,0,0,1,0,0, 32'h600,      32'h0,        32'h700,      1, 1, 32'h700,      1, 0));
    // ertn_flush leaves SQUASH; taken/taken target mismatch
    tbl.push_back(mk(1,0,0,0,0,0,0,1, 32'h704,      32'h0,        32'h0,        1, 0, 32'h700,      0, 0));
    tbl.push_back(mk(1,1,1,0,1,1,0,0, 32'h900,      32'h910,      32'h920,      1, 1, 32'h920,      1, 0));
    // reset during SQUASH with a mispredicting offer present
    tbl.push_back(mk(0,1,0,1,0,1,0,0, 32'h920,      32'h0,        32'hA00,      1, 0, 32'h0,        0, 0));
    tbl.push_back(mk(1,1,0,1,0,1,0,0, 32'hB00,      32'h0,        32'hB40,      1, 1, 32'hB40,      1, 1));
    tbl.push_back(mk(1,1,0,1,0,0,0,0, 32'hB40,      32'h0,        32'h0,        1, 0, 32'hB40,      1, 1));
    tbl.push_back(mk(1,1,1,0,1,1,0,0, 32'hB44,      32'hC00,      32'hC00,      1, 0, 32'hB40,      1, 0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 32'h0,        32'h0,        32'h0,        1, 0, 32'hB40,      0, 0));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Randomized traffic; small PC pool so squash matches occur often.
    for (int i = 0; i < 3000; i++) begin
      int k;
      k = int'($urandom_range(0, 3));
      r = mk(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0), (k == 1), (k >= 2),
             1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
             32'h1000 + 32'($urandom_range(0, 7)) * 4, 32'h1000 + 32'($urandom_range(0, 3)) * 4,
             32'h1000 + 32'($urandom_range(0, 3)) * 4, 0, 0, 32'h0, 0, 0);
      if (m_sq && $urandom_range(0, 2) == 0) r.pc = m_sqpc;
      step(r);
    end

`ifdef BRU_PERF_CNT_EN
    // Ten resolved branches, three of them mispredicted, each followed on the correct path.
    step(mk(0,0,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0));
    pc = 32'h2000;
    for (int i = 0; i < 10; i++) begin
      mis = (i == 2) || (i == 5) || (i == 8);
      step(mk(1, 1, (i % 3 == 0), (i % 3 != 0), 0, mis, 0, 0, pc, 32'h0, pc + 32'h40, 0, 0, 32'h0, 0, 0));
      pc = mis ? pc + 32'h40 : pc + 32'd4;
    end
    step(mk(1,0,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0));
    chk("perf_br_10", 99'(perf_br_cnt), 99'(32'd10));
    chk("perf_mis_3", 99'(perf_mis_cnt), 99'(32'd3));
`else
    pc = '0; mis = 0;
`endif

    // FIFO: fill to full, enqueue+dequeue while full, rejected enqueue, drain.
    @(negedge clk); f_rstn = 0;
    @(posedge clk); #1;
    @(negedge clk); f_rstn = 1;
    f_q.delete();
    for (int i = 0; i < 4; i++) fstep(1, 0, 8'(8'h10 + i));
    fstep(1, 1, 8'h14);
    fstep(1, 0, 8'h15);
    for (int i = 0; i < 5; i++) fstep(0, 1, 8'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter UQ_DEPTH, default 4, meaning update-queue entries (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1 bit, meaning the single clock.
REQ-003 SHALL have port rstn, input, 1 bit, meaning synchronous active-low reset.
REQ-004 SHALL have port E_valid, input, 1 bit, meaning the execute stage offers a resolved instruction.
REQ-005 SHALL have port E_pc, input, 32 bits, meaning the offered instruction PC.
REQ-006 SHALL have port E_inst, input, 32 bits, meaning the offered instruction word.
REQ-007 SHALL have port E_direct, input, 1 bit, meaning the instruction is jirl/b/bl.
REQ-008 SHALL have port E_cond, input, 1 bit, meaning the instruction is beq/bne/blt/bge/bltu/bgeu.
REQ-009 SHALL have ports E_pred_taken (input, 1 bit) and E_pred_target (input, 32 bits), meaning the prediction carried down the pipe.
REQ-010 SHALL have ports E_taken (input, 1 bit) and E_target (input, 32 bits), meaning the resolved outcome.
REQ-011 SHALL have port bru_allowin, output, 1 bit, meaning the offer is accepted this cycle.
REQ-012 SHALL have ports ex_en and ertn_flush, input, 1 bit each, meaning exception or ertn flush.
REQ-013 SHALL have port predict_error, output, 1 bit, meaning a one-cycle mispredict pulse.
REQ-014 SHALL have port redirect_pc, output, 32 bits, meaning the correct-path PC, valid while predict_error=1.
REQ-015 SHALL have port PB_BUS, output, 99 bits, meaning {inst[98:67], direct_jump[66], indirect_jump[65] (=cond), br_taken[64], br_target[63:32], pc[31:0]}; all-zero when idle.

Function
REQ-016 SHALL accept an offer when E_valid && bru_allowin; bru_allowin = !(E_direct|E_cond) || !uq_full || uq_deq.
REQ-017 SHALL flag a mispredict on an accepted branch when E_pred_taken!=E_taken, or when both are 1 and E_pred_target!=E_target.
REQ-018 SHALL set redirect_pc = E_taken ? E_target : E_pc+4.
REQ-019 SHALL assert predict_error and redirect_pc from registers, exactly one cycle after the accepting edge, for one cycle.
REQ-020 SHALL implement FSM RUN/SQUASH: RUN->SQUASH on a mispredict; SQUASH->RUN when an accepted offer has E_pc==saved redirect_pc, or on ex_en|ertn_flush.
REQ-021 SHALL, in SQUASH, accept but neither resolve nor enqueue offers with E_pc!=saved redirect_pc; the matching offer is resolved normally in the same cycle.
REQ-022 SHALL enqueue every resolved branch (direct or cond) into an UQ_DEPTH FIFO; non-branches are accepted and discarded.
REQ-023 SHALL dequeue one entry per cycle when non-empty, driving PB_BUS from the head register; PB_BUS=0 when empty.
REQ-024 SHALL permit enqueue and dequeue in the same cycle when full, with count unchanged.
REQ-025 SHALL wrap head/tail pointers modulo UQ_DEPTH; count SHALL be $clog2(UQ_DEPTH)+1 bits wide.
REQ-026 SHALL, on ex_en|ertn_flush, suppress resolution of that cycle's offer and enter RUN without flushing the queue; a flush has priority over a same-cycle mispredict.

Reset
REQ-027 SHALL reset synchronously while rstn=0: FSM=RUN, queue empty, predict_error=0, redirect_pc=0, PB_BUS=0, perf counters=0.
REQ-028 SHALL discard a pending mispredict pulse and queued entries when reset occurs mid-operation.

Configuration
REQ-029 SHALL, with macro BRU_PERF_CNT_EN defined, add 32-bit outputs perf_br_cnt and perf_mis_cnt that count resolved branches and mispredicts, saturating at 32'hFFFFFFFF.
REQ-030 SHALL, without BRU_PERF_CNT_EN, omit those ports and counters, with no other behavioural change.

Structure
REQ-031 SHALL take PB_BUS_Wid (99) and the field offsets from the shared defines header used by the predictor.
REQ-032 SHALL place the FIFO in one sub-module, bru_update_fifo (parameterized width and depth, synchronous reset).

Verification
REQ-033 SHALL cover: beq at pc 0x1C000010 with pred_taken=0 and taken=1, target 0x1C000040 -> next cycle predict_error=1, redirect_pc=0x1C000040; PB_BUS.indirect_jump=1.
REQ-034 SHALL cover: b with pred_taken=1, pred_target=0x100 and E_target=0x104 -> mispredict with redirect 0x104; two following offers at 0x200/0x204 are squashed until pc 0x104 arrives.
REQ-035 SHALL cover: UQ_DEPTH=4 with the queue made full -> bru_allowin stays 1 because a dequeue occurs each cycle; a forced full queue with no dequeue -> bru_allowin=0 for a branch and 1 for an ALU op.
REQ-036 SHALL cover: a mispredict and ex_en in the same cycle -> no predict_error pulse and FSM=RUN.
REQ-037 SHALL cover: rstn=0 asserted during SQUASH with 3 entries queued -> next cycle PB_BUS=0, predict_error=0, FSM=RUN.
REQ-038 SHALL cover, with BRU_PERF_CNT_EN defined: 10 branches including 3 mispredicts -> perf_br_cnt=10, perf_mis_cnt=3.
